// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Pipeline stage register with a valid/ready handshake. It can carry an
// optional one-entry skid buffer and a "late capture" field. The late capture
// holds data such as a load result that arrives while the head entry is
// stalled downstream.
//
// Parameters
//   DATA_W : payload width (pc, instr, operands, control packed by the user)
//   CAP_W  : late-capture field width
//   SKID   : 1 = head + one skid entry (in_ready fully registered)
//            0 = single register (in_ready = !out_valid || out_ready)
//
// Ports
//   CLK, nRST            : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  : upstream handshake
//   in_data              : upstream payload
//   out_valid / out_ready: downstream handshake
//   out_data             : head payload
//   flush                : squash every entry, overrides all other events
//   cap_en / cap_data    : capture strobe and value for the stalled head
//   out_cap / out_cap_vld: captured value for the head (bypassed if none yet)
//   count                : occupancy 0..2
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CAP_W  = 32,
    parameter int SKID   = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              cap_en,
    input  logic [CAP_W-1:0]  cap_data,
    output logic [CAP_W-1:0]  out_cap,
    output logic              out_cap_vld,
    output logic [1:0]        count
);

    // The encoding equals the occupancy, so count is a direct copy of the state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   head_q, head_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic [CAP_W-1:0]    cap_q, cap_d;
    logic                cap_vld_q, cap_vld_d;

    logic                xfer_in;
    logic                xfer_out;

    // ---------------------------------------------------------------------
    // Upstream ready
    // ---------------------------------------------------------------------
    generate
        if (SKID != 0) begin : g_skid
            // The skid slot absorbs the beat that is in flight while a stall
            // propagates upstream. This removes any out_ready -> in_ready path.
            assign in_ready = (state_q != TWO);
        end else begin : g_noskid
            assign in_ready = (state_q == EMPTY) || out_ready;
        end
    endgenerate

    assign out_valid   = (state_q != EMPTY);
    assign out_data    = head_q;
    assign count       = state_q;
    assign out_cap_vld = cap_vld_q;

    // Without a stored capture, forward the live strobe data. A hit that
    // lands on the same edge as the transfer out then still reaches the
    // consumer.
    assign out_cap = cap_vld_q ? cap_q : cap_data;

    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = out_valid && out_ready;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        skid_d    = skid_q;
        cap_d     = cap_q;
        cap_vld_d = cap_vld_q;

        if (flush) begin
            state_d   = EMPTY;
            cap_d     = '0;
            cap_vld_d = 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (xfer_in) begin
                        head_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (xfer_in && xfer_out) begin
                        head_d = in_data;
                    end else if (xfer_out) begin
                        state_d = EMPTY;
                    end else if (xfer_in && (SKID != 0)) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (xfer_out) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase

            // The capture belongs to the head entry. It is dropped when the
            // head leaves. Otherwise the first strobe seen during a stall
            // is latched.
            if (xfer_out) begin
                cap_d     = '0;
                cap_vld_d = 1'b0;
            end else if (cap_en && out_valid && !cap_vld_q) begin
                cap_d     = cap_data;
                cap_vld_d = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= EMPTY;
            head_q    <= '0;
            skid_q    <= '0;
            cap_q     <= '0;
            cap_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            skid_q    <= skid_d;
            cap_q     <= cap_d;
            cap_vld_q <= cap_vld_d;
        end
    end

endmodule
